motor_controller: RTL and testbench
===================================

# motor_controller

Dual-channel H-bridge driver for the balance robot's two DC drive motors. It converts a signed speed command per motor (direction bit plus 7-bit duty value) into an L293-style drive: one PWM enable line and two direction lines per bridge half-pair. It sits between the control logic, which supplies the commands, and the FPGA pins. It runs on the divided clock generated in `top`, derived from the internal HSOSC.

## Interface
Parameters:
- `FRAME`, 100: clocks per PWM frame; duty values are in units of 1/FRAME.
- `DEAD_CYCLES`, 4: coast clocks inserted on a direction reversal.

Ports:
- `clk`, in, 1: single clock; all state on its rising edge.
- `reset`, in, 1: synchronous, active-low reset. The port is named `reset`.
- `motor1_sign`, in, 1: motor 1 direction; 1 = forward, 0 = reverse.
- `motor1_period`, in, 7: motor 1 duty in clocks per frame, 0..127.
- `motor2_sign`, in, 1: motor 2 direction.
- `motor2_period`, in, 7: motor 2 duty.
- `enable12`, out, 1: PWM enable for bridge 1/2 (motor 1).
- `enable34`, out, 1: PWM enable for bridge 3/4 (motor 2).
- `a1`, `a2`, out, 1 each: motor 1 direction lines.
- `a3`, `a4`, out, 1 each: motor 2 direction lines.

## Operation
- A shared frame counter `cnt` counts 0..FRAME-1 and wraps to 0.
- Frame boundary (cnt wraps to 0, or the first edge after reset deasserts):
  - each channel latches its sign and period;
  - period is clamped to FRAME, so values 101..127 are treated as 100.
  - Inputs changing mid-frame have no effect until the next boundary.
- Enable: high when `cnt < duty_latched` and the channel is not in dead time. Period 0 gives constant low; period ≥ FRAME gives constant high.
- Direction outputs:
  - forward: a1=1, a2=0 (a3=1, a4=0 for motor 2);
  - reverse: a1=0, a2=1;
  - coast: both 0.
- Channel state machine, one per channel: IDLE → DRIVE → DEAD → DRIVE.
  - IDLE (after reset): direction lines 0, enable 0. At the first boundary the channel goes to DRIVE with the latched sign and no dead time.
  - DRIVE: at a boundary where the latched sign equals the applied sign, stay in DRIVE. If the sign differs, go to DEAD.
  - DEAD: direction lines 0 and enable 0 for exactly DEAD_CYCLES clocks (cnt 0..DEAD_CYCLES-1). Then apply the new direction and return to DRIVE.
  - Duty in a DEAD frame is still counted from cnt=0, so the dead time consumes part of the duty.
- The two channels are fully independent apart from the shared `cnt`.

## Timing
- All outputs are registered. The value shown during the clock where cnt=c is computed on the edge that loads cnt=c.
- Reset (`reset`=0 at a rising edge):
  - cnt=0; both channels go to IDLE;
  - enable12=enable34=0; a1..a4=0.
  - Reset takes effect from any point mid-frame, with no partial-frame output afterwards.
- The first edge with `reset`=1 is a frame boundary and samples the inputs. Enable and direction for that frame are valid from that edge.
- Command latency: a change becomes effective at the next frame boundary. Worst case is FRAME clocks plus one edge.
- Per frame, enable is high for exactly min(period, FRAME) clocks, contiguous from cnt=0. In a DEAD frame it is high for max(0, min(period, FRAME) − DEAD_CYCLES) clocks, from cnt=DEAD_CYCLES.
- No combinational path from inputs to outputs.

## Structure
- Shared package `motor_pkg`:
  - `dir_t` enum: FWD, REV, COAST;
  - channel state enum: IDLE, DRIVE, DEAD;
  - `DUTY_W` = 7.
- Sub-module `pwm_channel`, instantiated twice. It holds the per-channel latch, clamp, state machine and output registers, and takes `cnt` and a `frame_start` strobe as inputs.
- The top level holds the frame counter and the two instances.

## Test plan
- Reset: hold `reset`=0 for 3 clocks with commands sign1=1/period 30, sign2=0/period 100. Required: all outputs 0. After release:
  - enable12 is high 30 of every 100 clocks and a1=1, a2=0;
  - enable34 is constantly high and a3=0, a4=1.
- Clamp: period 127 gives enable constantly high; period 0 gives enable constantly low with direction still driven.
- Mid-frame change: period goes 50→20 at cnt=10. Required: the current frame stays at 50 high clocks and the next frame has 20.
- Reversal: motor1 sign 1→0 with period 50. Required:
  - next frame: a1=a2=0 and enable12=0 for cnt 0..3;
  - from cnt 4: a1=0, a2=1, and enable12 high for cnt 4..49.
- Reset mid-frame: assert at cnt=60. Required: outputs 0 on the next edge. After release, cnt restarts at 0 with no dead time.
- Independence: motor1 reverses while motor2 holds steady. Required: enable34, a3 and a4 are unaffected.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and widths for the dual H-bridge motor driver.
package motor_pkg;

    localparam int DUTY_W = 7;

    typedef enum logic [1:0] {FWD, REV, COAST} dir_t;

    typedef enum logic [1:0] {IDLE, DRIVE, DEAD} state_t;

    function automatic dir_t sign_to_dir(input logic sign);
        return sign ? FWD : REV;
    endfunction

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] period,
                                                     input logic [DUTY_W-1:0] limit);
        return (period > limit) ? limit : period;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One H-bridge channel: frame-latched command, reversal dead time, registered drive lines.
module pwm_channel
    import motor_pkg::*;
#(
    parameter int FRAME       = 100,
    parameter int DEAD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] cnt,
    input  logic              frame_start,
    input  logic              sign,
    input  logic [DUTY_W-1:0] period,
    output logic              enable,
    output logic              dir_a,
    output logic              dir_b
);

    localparam logic [DUTY_W-1:0] FRAME_D = DUTY_W'(FRAME);
    localparam logic [DUTY_W-1:0] DEAD_D  = DUTY_W'(DEAD_CYCLES);

    state_t            state;
    dir_t              applied;
    dir_t              pending;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_new;
    dir_t              dir_new;

    assign duty_new = clamp_duty(period, FRAME_D);
    assign dir_new  = sign_to_dir(sign);

    // cnt is the value being loaded on this edge, so outputs line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            applied <= COAST;
            pending <= COAST;
            duty_q  <= '0;
            enable  <= 1'b0;
            dir_a   <= 1'b0;
            dir_b   <= 1'b0;
        end else if (frame_start) begin
            duty_q  <= duty_new;
            pending <= dir_new;
            if (state == IDLE || dir_new == applied) begin
                state   <= DRIVE;
                applied <= dir_new;
                enable  <= (cnt < duty_new);
                dir_a   <= (dir_new == FWD);
                dir_b   <= (dir_new == REV);
            end else begin
                state   <= DEAD;
                applied <= COAST;
                enable  <= 1'b0;
                dir_a   <= 1'b0;
                dir_b   <= 1'b0;
            end
        end else if (state == DEAD && cnt == DEAD_D) begin
            // Dead time over: the reversed direction takes over mid-frame.
            state   <= DRIVE;
            applied <= pending;
            enable  <= (cnt < duty_q);
            dir_a   <= (pending == FWD);
            dir_b   <= (pending == REV);
        end else if (state == DRIVE) begin
            enable <= (cnt < duty_q);
        end
    end

endmodule

// File: rtl/motor_controller.sv
// Dual-channel L293-style driver: shared PWM frame counter feeding two independent channels.
module motor_controller
    import motor_pkg::*;
#(
    parameter int FRAME       = 100,
    parameter int DEAD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              motor1_sign,
    input  logic [DUTY_W-1:0] motor1_period,
    input  logic              motor2_sign,
    input  logic [DUTY_W-1:0] motor2_period,
    output logic              enable12,
    output logic              enable34,
    output logic              a1,
    output logic              a2,
    output logic              a3,
    output logic              a4
);

    localparam logic [DUTY_W-1:0] LAST = DUTY_W'(FRAME - 1);

    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] cnt_next;
    logic              first;
    logic              frame_start;

    // The first edge out of reset is itself a frame boundary.
    always_comb begin
        frame_start = first || (cnt == LAST);
        cnt_next    = frame_start ? '0 : cnt + DUTY_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            first <= 1'b1;
        end else begin
            cnt   <= cnt_next;
            first <= 1'b0;
        end
    end

    pwm_channel #(.FRAME(FRAME), .DEAD_CYCLES(DEAD_CYCLES)) u_ch1 (
        .clk        (clk),
        .reset      (reset),
        .cnt        (cnt_next),
        .frame_start(frame_start),
        .sign       (motor1_sign),
        .period     (motor1_period),
        .enable     (enable12),
        .dir_a      (a1),
        .dir_b      (a2)
    );

    pwm_channel #(.FRAME(FRAME), .DEAD_CYCLES(DEAD_CYCLES)) u_ch2 (
        .clk        (clk),
        .reset      (reset),
        .cnt        (cnt_next),
        .frame_start(frame_start),
        .sign       (motor2_sign),
        .period     (motor2_period),
        .enable     (enable34),
        .dir_a      (a3),
        .dir_b      (a4)
    );

endmodule

// File: tb/tb_motor_controller.sv
// Bench for motor_controller: frame-level reference model scored every clock, plus per-frame vector table.
module tb_motor_controller;

    localparam int FRAME = 100;
    localparam int DEAD  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s1 = 1'b0, s2 = 1'b0;
    logic [6:0] p1 = '0, p2 = '0;
    logic       enable12, enable34, a1, a2, a3, a4;

    motor_controller #(.FRAME(FRAME), .DEAD_CYCLES(DEAD)) dut (
        .clk          (clk),
        .reset        (reset),
        .motor1_sign  (s1),
        .motor1_period(p1),
        .motor2_sign  (s2),
        .motor2_period(p2),
        .enable12     (enable12),
        .enable34     (enable34),
        .a1           (a1),
        .a2           (a2),
        .a3           (a3),
        .a4           (a4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic en12, en34, a1, a2, a3, a4;
    } obs_t;

    typedef struct {
        bit s1; int p1; bit s2; int p2;
        int h1; int h2;
    } vec_t;

    obs_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hi1, hi2;

    // Reference model: per-frame latched command, dead flag set when sign flips between frames.
    int m_cnt = 0;
    bit m_first = 1;
    bit m_act[2];
    bit m_sign[2];
    int m_duty[2];
    bit m_dead[2];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        obs_t e;
        obs_t got;
        bit   bnd;
        bit   s[2];
        int   p[2];
        bit   en[2], da[2], db[2];
        s[0] = s1; s[1] = s2; p[0] = int'(p1); p[1] = int'(p2);
        e = '0;
        if (!reset) begin
            m_cnt = 0; m_first = 1;
            m_act[0] = 0; m_act[1] = 0;
        end else begin
            bnd = m_first || (m_cnt == FRAME - 1);
            m_cnt = bnd ? 0 : m_cnt + 1;
            m_first = 0;
            for (int c = 0; c < 2; c++) begin
                if (bnd) begin
                    m_dead[c] = m_act[c] && (s[c] != m_sign[c]);
                    m_act[c]  = 1;
                    m_sign[c] = s[c];
                    m_duty[c] = (p[c] > FRAME) ? FRAME : p[c];
                end
                en[c] = 0; da[c] = 0; db[c] = 0;
                if (m_act[c] && !(m_dead[c] && m_cnt < DEAD)) begin
                    en[c] = (m_cnt < m_duty[c]);
                    da[c] = m_sign[c];
                    db[c] = !m_sign[c];
                end
            end
            e = '{en12: en[0], en34: en[1], a1: da[0], a2: db[0], a3: da[1], a4: db[1]};
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = '{en12: enable12, en34: enable34, a1: a1, a2: a2, a3: a3, a4: a4};
        e = sb_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            if (errors <= 20)
                $display("FAIL cycle_out cnt=%0d: got %b expected %b", m_cnt, got, e);
        end
        hi1 += int'(enable12);
        hi2 += int'(enable34);
    endtask

    task automatic run_frame();
        hi1 = 0; hi2 = 0;
        repeat (FRAME) tick();
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{s1: 1, p1: 30,  s2: 0, p2: 100, h1: 30,  h2: 100};
        vt[1] = '{s1: 1, p1: 127, s2: 0, p2: 0,   h1: 100, h2: 0};
        vt[2] = '{s1: 1, p1: 0,   s2: 0, p2: 55,  h1: 0,   h2: 55};
        vt[3] = '{s1: 0, p1: 50,  s2: 0, p2: 55,  h1: 46,  h2: 55};
        vt[4] = '{s1: 0, p1: 50,  s2: 0, p2: 55,  h1: 50,  h2: 55};
        vt[5] = '{s1: 1, p1: 2,   s2: 1, p2: 100, h1: 0,   h2: 96};
        vt[6] = '{s1: 1, p1: 100, s2: 1, p2: 3,   h1: 100, h2: 3};

        // Reset held for three clocks with the first command already present.
        s1 = 1; p1 = 7'd30; s2 = 0; p2 = 7'd100;
        reset = 0;
        repeat (3) tick();
        chk("reset_outputs", int'({enable12, enable34, a1, a2, a3, a4}), 0);
        reset = 1;

        for (int i = 0; i < 7; i++) begin
            s1 = vt[i].s1; p1 = 7'(vt[i].p1);
            s2 = vt[i].s2; p2 = 7'(vt[i].p2);
            run_frame();
            chk($sformatf("v%0d_hi12", i), hi1, vt[i].h1);
            chk($sformatf("v%0d_hi34", i), hi2, vt[i].h2);
            chk($sformatf("v%0d_a1a2", i), int'({a1, a2}), vt[i].s1 ? 2 : 1);
            chk($sformatf("v%0d_a3a4", i), int'({a3, a4}), vt[i].s2 ? 2 : 1);
        end

        // Mid-frame command change only lands at the next boundary.
        p1 = 7'd50;
        hi1 = 0; hi2 = 0;
        repeat (10) tick();
        p1 = 7'd20;
        repeat (FRAME - 10) tick();
        chk("midframe_cur", hi1, 50);
        run_frame();
        chk("midframe_next", hi1, 20);

        // Reset at cnt=60, with a sign flip pending: no dead time afterwards.
        repeat (61) tick();
        reset = 0;
        s1 = 0;
        tick();
        chk("midreset_outputs", int'({enable12, enable34, a1, a2, a3, a4}), 0);
        reset = 1;
        hi1 = 0; hi2 = 0;
        tick();
        chk("release_a1a2", int'({a1, a2}), 1);
        chk("release_en12", int'(enable12), 1);
        repeat (FRAME - 1) tick();
        chk("release_hi12", hi1, 20);
        chk("release_hi34", hi2, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
